imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory port: accepts a byte stream from the UART receiver and writes little-endian 32-bit words into program ROM.
- The fetch stage reads that memory; upg_done_o gates the CPU. The CPU fetches only while upg_done_o=1.
- Frame format: 2-byte little-endian word count N, then N*4 data bytes, least significant byte first.

Parameters:
- ADDR_W, 14, word-address width of instruction memory; depth = 2^ADDR_W.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle pulse; begins (or restarts) a load.
- rx_valid_i  in  1  single-cycle strobe; rx_data_i is valid.
- rx_data_i  in  8  received byte.
- upg_wen_o  out  1  instruction-memory write enable, one cycle per word.
- upg_adr_o  out  ADDR_W  word address of the write.
- upg_dat_o  out  32  write data.
- upg_done_o  out  1  1 = memory is not being loaded; CPU may fetch.
- busy_o  out  1  a frame is in progress.
- err_o  out  1  sticky: last load aborted.

Behaviour:
- Reset values: state IDLE, upg_done_o=1, busy_o=0, err_o=0, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, all internal counters 0.
- States:
  - IDLE: upg_done_o=1. start_i -> LEN_LO, which clears err_o and the word index and sets upg_done_o=0.
  - LEN_LO: on a byte, latch count[7:0] -> LEN_HI.
  - LEN_HI: on a byte, latch count[15:8]. If count==0 or count>2^ADDR_W -> ERR, else -> DATA.
  - DATA: shift bytes into the assembly register, little-endian. On the 4th byte of a word, the next cycle drives upg_wen_o=1 for exactly one cycle, with upg_adr_o = word index and upg_dat_o = assembled word. The word index then increments. The write of word N-1 is followed by DONE on the next cycle.
  - DONE: upg_done_o=1, busy_o=0 -> IDLE next cycle.
  - ERR: err_o=1, upg_done_o=1 -> IDLE next cycle.
- busy_o=1 in LEN_LO, LEN_HI and DATA only.
- Latency: 1 cycle from the 4th byte strobe to upg_wen_o. Back-to-back rx_valid_i every cycle must be supported without loss.
- Timeout: an idle counter runs in LEN_LO, LEN_HI and DATA and resets on every rx_valid_i. Reaching TIMEOUT_CYCLES -> ERR. A partially assembled word is discarded; words already written remain.
- rx_valid_i in IDLE, DONE or ERR is ignored.
- start_i while busy: abort the frame without setting err_o and restart at LEN_LO with word index 0.
- start_i with rx_valid_i in the same cycle: start wins; the byte is dropped.
- rx_valid_i in the cycle the timeout would expire: the byte wins and the counter resets.
- Word-index arithmetic is ADDR_W+1 bits. N=2^ADDR_W is legal and the last address is 2^ADDR_W-1; no wrap-around is allowed.
- rst mid-frame: immediately return to reset values; no further writes.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR);
  - constant WORD_BYTES=4;
  - constant LEN_BYTES=2.
- One natural sub-module, imem_loader_timeout: a loadable idle counter with clear and enable inputs and an expired output.

Test Plan:
- Reset, then a frame for N=1 (bytes 01 00 78 56 34 12) -> one upg_wen_o pulse with adr=0 and dat=0x12345678; then DONE, upg_done_o=1, err_o=0.
- N=3 with bytes streamed every cycle -> 3 wen pulses at adr 0,1,2, each 1 cycle after its 4th byte; busy_o falls after the third.
- Length bytes 00 00 -> ERR, err_o=1, no writes. Length 01 40 (N=16385) with ADDR_W=14 -> err_o=1, no writes.
- TIMEOUT_CYCLES=16, N=2, stall 16 cycles after the 6th byte -> err_o=1, exactly one write at adr 0, upg_done_o=1.
- Mid-frame start_i after 5 data bytes, then a full N=1 frame -> no err_o; the only writes are adr=0 for word 0 of the first frame and adr=0 with the new data.
- Assert rst in DATA with 2 bytes pending -> next cycle shows reset values; subsequent rx bytes produce no writes until start_i.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the frame geometry (length-field size, bytes per instruction word).
// No ports.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LEN_BYTES  = 2;

endpackage

// File: rtl/imem_loader_timeout.sv
// imem_loader_timeout
// Idle watchdog for the loader. Down-counter reloaded to TIMEOUT_CYCLES on
// every accepted byte; expires when TIMEOUT_CYCLES consecutive enabled
// cycles pass without a reload.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   load_i     reload the counter (a byte arrived or a frame starts)
//   clr_i      park the counter at zero (no frame in progress)
//   en_i       count this cycle (frame in progress)
//   expired_o  this is the last idle cycle allowed; abort at the next edge
module imem_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= LOAD_VAL;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Terminal count is 1, not 0: the cycle holding 1 is the N-th idle cycle.
    // A reload in that same cycle wins, so a late byte still rescues the frame.
    assign expired_o = en_i && !load_i && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Writer side of the instruction-memory port. Receives a UART byte stream
// framed as a 2-byte little-endian word count N followed by N little-endian
// 32-bit words, and writes each word to program memory. upg_done_o gates
// instruction fetch in the CPU.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start_i      pulse: begin or restart a load
//   rx_valid_i   pulse: rx_data_i holds a received byte
//   rx_data_i    received byte
//   upg_wen_o    memory write enable, one cycle per word
//   upg_adr_o    word address of the write
//   upg_dat_o    write data
//   upg_done_o   1 = memory not being loaded, CPU may fetch
//   busy_o       a frame is in progress
//   err_o        sticky: last load aborted (bad length or idle timeout)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no load in progress, CPU may fetch
// ST_LEN_LO | waiting for word count bits [7:0]
// ST_LEN_HI | waiting for word count bits [15:8], then range check
// ST_DATA   | assembling words and writing them out
// ST_DONE   | all N words written, one cycle, then IDLE
// ST_ERR    | frame aborted, one cycle, then IDLE
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int LEN_W  = 8 * LEN_BYTES;
    localparam int BCNT_W = $clog2(WORD_BYTES);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    state_t            r_state;
    logic [LEN_W-1:0]  r_count;
    logic [ADDR_W:0]   r_widx;    // one extra bit so N = 2^ADDR_W is representable
    logic [BCNT_W-1:0] r_bcnt;
    logic [23:0]       r_asm;     // the three most recent bytes of the current word
    logic              r_wen;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_dat;
    logic              r_done;
    logic              r_busy;
    logic              r_err;

    logic [LEN_W-1:0]  w_len;
    logic [31:0]       w_word;
    logic              w_len_bad;
    logic              w_frame_full;
    logic              w_expired;
    logic              w_abort;

    assign w_len        = {rx_data_i, r_count[7:0]};
    assign w_word       = {rx_data_i, r_asm};
    assign w_len_bad    = (w_len == '0) || (32'(w_len) > DEPTH);
    assign w_frame_full = (32'(r_widx) == 32'(r_count));

    // The cycle that follows the final write always completes the frame, even
    // if the watchdog happens to expire in that same cycle.
    assign w_abort = w_expired && !((r_state == ST_DATA) && w_frame_full);

    imem_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (start_i || (rx_valid_i && r_busy)),
        .clr_i     (!r_busy),
        .en_i      (r_busy),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_widx  <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_wen   <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (start_i) begin
                // Restart from any state; a byte in the same cycle is dropped.
                r_state <= ST_LEN_LO;
                r_count <= '0;
                r_widx  <= '0;
                r_bcnt  <= '0;
                r_asm   <= '0;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
                r_err   <= 1'b0;
            end else if (w_abort) begin
                r_state <= ST_ERR;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_LEN_LO: begin
                        if (rx_valid_i) begin
                            r_count[7:0] <= rx_data_i;
                            r_state      <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_valid_i) begin
                            r_count <= w_len;
                            if (w_len_bad) begin
                                r_state <= ST_ERR;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_frame_full) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (rx_valid_i) begin
                            r_asm  <= w_word[31:8];
                            r_bcnt <= r_bcnt + BCNT_W'(1);
                            if (r_bcnt == LAST_BYTE) begin
                                r_wen  <= 1'b1;
                                r_adr  <= r_widx[ADDR_W-1:0];
                                r_dat  <= w_word;
                                r_widx <= r_widx + (ADDR_W+1)'(1);
                            end
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    ST_ERR:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign upg_wen_o  = r_wen;
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign upg_done_o = r_done;
    assign busy_o     = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader (ADDR_W=14, TIMEOUT_CYCLES=16). A table of
// per-cycle {inputs, expected outputs} rows covers the normal frames, length
// boundaries and restart cases; hand-written sequences cover the idle
// timeout and a synchronous reset in the middle of a frame.
module tb_imem_loader;

    localparam int ADDR_W = 14;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              busy_o;
    logic              err_o;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              st;
        logic              vl;
        logic [7:0]        d;
        logic              wen;
        logic [ADDR_W-1:0] adr;
        logic [31:0]       dat;
        logic              done;
        logic              busy;
        logic              err;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   n_wr   = 0;

    always @(negedge clk) begin
        if (!rst && upg_wen_o) n_wr <= n_wr + 1;
    end

    task automatic add(input int s, input int v, input int d, input int wen,
                       input int adr, input logic [31:0] dat,
                       input int done, input int busy, input int err);
        vec_t r;
        r.st   = (s != 0);
        r.vl   = (v != 0);
        r.d    = 8'(d);
        r.wen  = (wen != 0);
        r.adr  = ADDR_W'(adr);
        r.dat  = dat;
        r.done = (done != 0);
        r.busy = (busy != 0);
        r.err  = (err != 0);
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start_i    = s;
        rx_valid_i = v;
        rx_data_i  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), 64'({1'b0, 14'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
        @(negedge clk); rst = 1'b0;

        // bytes in IDLE are ignored
        add(0,1,'h55, 0,0,32'h0,        1,0,0);
        add(0,0,'h00, 0,0,32'h0,        1,0,0);
        // N=1: 01 00 78 56 34 12
        add(1,0,'h00, 0,0,32'h0,        0,1,0);
        add(0,1,'h01, 0,0,32'h0,        0,1,0);
        add(0,1,'h00, 0,0,32'h0,        0,1,0);
        add(0,1,'h78, 0,0,32'h0,        0,1,0);
        add(0,1,'h56, 0,0,32'h0,        0,1,0);
        add(0,1,'h34, 0,0,32'h0,        0,1,0);
        add(0,1,'h12, 1,0,32'h12345678, 0,1,0);
        add(0,0,'h00, 0,0,32'h12345678, 1,0,0);
        add(0,1,'h99, 0,0,32'h12345678, 1,0,0);
        // N=3 streamed back to back
        add(1,0,'h00, 0,0,32'h12345678, 0,1,0);
        add(0,1,'h03, 0,0,32'h12345678, 0,1,0);
        add(0,1,'h00, 0,0,32'h12345678, 0,1,0);
        add(0,1,'h11, 0,0,32'h12345678, 0,1,0);
        add(0,1,'h22, 0,0,32'h12345678, 0,1,0);
        add(0,1,'h33, 0,0,32'h12345678, 0,1,0);
        add(0,1,'h44, 1,0,32'h44332211, 0,1,0);
        add(0,1,'h55, 0,0,32'h44332211, 0,1,0);
        add(0,1,'h66, 0,0,32'h44332211, 0,1,0);
        add(0,1,'h77, 0,0,32'h44332211, 0,1,0);
        add(0,1,'h88, 1,1,32'h88776655, 0,1,0);
        add(0,1,'h99, 0,1,32'h88776655, 0,1,0);
        add(0,1,'haa, 0,1,32'h88776655, 0,1,0);
        add(0,1,'hbb, 0,1,32'h88776655, 0,1,0);
        add(0,1,'hcc, 1,2,32'hccbbaa99, 0,1,0);
        add(0,0,'h00, 0,2,32'hccbbaa99, 1,0,0);
        add(0,0,'h00, 0,2,32'hccbbaa99, 1,0,0);
        // zero length
        add(1,0,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h00, 0,2,32'hccbbaa99, 1,0,1);
        add(0,0,'h00, 0,2,32'hccbbaa99, 1,0,1);
        // N=16385 exceeds depth
        add(1,0,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h01, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h40, 0,2,32'hccbbaa99, 1,0,1);
        add(0,0,'h00, 0,2,32'hccbbaa99, 1,0,1);
        // N=16384 is accepted, then restarted
        add(1,0,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h40, 0,2,32'hccbbaa99, 0,1,0);
        add(0,0,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(1,0,'h00, 0,2,32'hccbbaa99, 0,1,0);
        // N=2, abort after 5 data bytes; restart carries a byte that must drop
        add(0,1,'h02, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'h00, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'ha1, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'hb2, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'hc3, 0,2,32'hccbbaa99, 0,1,0);
        add(0,1,'hd4, 1,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'he5, 0,0,32'hd4c3b2a1, 0,1,0);
        add(1,1,'h05, 0,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'h01, 0,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'h00, 0,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'h0d, 0,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'hf0, 0,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'had, 0,0,32'hd4c3b2a1, 0,1,0);
        add(0,1,'hde, 1,0,32'hdeadf00d, 0,1,0);
        add(0,0,'h00, 0,0,32'hdeadf00d, 1,0,0);
        add(0,0,'h00, 0,0,32'hdeadf00d, 1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].vl, tbl[i].d);
            chk($sformatf("vec%0d", i), outs(),
                64'({tbl[i].wen, tbl[i].adr, tbl[i].dat, tbl[i].done, tbl[i].busy, tbl[i].err}));
        end

        // idle timeout: N=2, one word written, then stall
        w0 = n_wr;
        step(1, 0, 8'h00);
        step(0, 1, 8'h02);
        step(0, 1, 8'h00);
        step(0, 1, 8'h10);
        step(0, 1, 8'h20);
        step(0, 1, 8'h30);
        step(0, 1, 8'h40);
        repeat (TMO - 1) step(0, 0, 8'h00);
        chk("tmo_before_expiry", 64'({busy_o, err_o}), 64'b10);
        step(0, 1, 8'h50);
        chk("tmo_byte_wins", 64'({busy_o, err_o}), 64'b10);
        repeat (TMO - 1) step(0, 0, 8'h00);
        chk("tmo_not_early", 64'({busy_o, err_o}), 64'b10);
        step(0, 0, 8'h00);
        chk("tmo_err", 64'({upg_done_o, busy_o, err_o}), 64'b101);
        step(0, 0, 8'h00);
        chk("tmo_writes", 64'(n_wr - w0), 64'd1);
        chk("tmo_last_write", 64'({upg_adr_o, upg_dat_o}), 64'({14'd0, 32'h40302010}));

        // synchronous reset in DATA with two bytes of a word pending
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'haa);
        step(0, 1, 8'hbb);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_frame", outs(), 64'({1'b0, 14'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
        @(negedge clk); rst = 1'b0;
        w0 = n_wr;
        step(0, 1, 8'hcc);
        step(0, 1, 8'hdd);
        step(0, 1, 8'hee);
        step(0, 1, 8'hff);
        step(0, 1, 8'h11);
        step(0, 0, 8'h00);
        chk("rst_no_writes", 64'(n_wr - w0), 64'd0);
        chk("rst_idle_flags", 64'({upg_done_o, busy_o, err_o}), 64'b100);

        // recovery after reset
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'hef);
        step(0, 1, 8'hbe);
        step(0, 1, 8'had);
        step(0, 1, 8'hde);
        chk("recover_write", outs(), 64'({1'b1, 14'd0, 32'hdeadbeef, 1'b0, 1'b1, 1'b0}));
        step(0, 0, 8'h00);
        chk("recover_done", 64'({upg_done_o, busy_o, err_o}), 64'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
